// File: rtl/count_sequencer_pkg.sv
// Shared types and constants for the count sequencer: FSM state encoding,
// counter width and a saturating increment helper.
package count_sequencer_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/count8_core.sv
// 8-bit count register with synchronous clear (priority) and count enable.
module count8_core
   import count_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!reset || clr)
         q <= '0;
      else if (en)
         q <= q + 1'b1;
   end

endmodule

// File: rtl/count_sequencer.sv
// Start/stop/pause count sequencer with one-shot or auto-reload periods.
// Auto-reload is built only when COUNT_SEQUENCER_AUTO_RELOAD_EN is defined.
module count_sequencer
   import count_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [CNT_W-1:0] limit,
   input  logic             reload,
   output logic [CNT_W-1:0] q,
   output logic             t,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] wraps
);

   state_t           state;
   logic [CNT_W-1:0] limit_r;
   logic             reload_r;
   logic             active;
   logic             at_limit;
   logic             accept;
   logic             clr;
   logic             en;

   assign active   = (state == RUN) || (state == HOLD);
   assign at_limit = (q == limit_r);
   assign accept   = (state == IDLE) && start && !stop;

   // HOLD shares RUN's decode, so dropping pause counts on that same edge.
   assign clr = accept || (active && stop) || (active && at_limit && reload_r);
   assign en  = active && !stop && !at_limit && !pause;

   count8_core u_core (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (en),
      .q     (q)
   );

`ifndef COUNT_SEQUENCER_AUTO_RELOAD_EN
   logic unused_reload;
   assign unused_reload = reload;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         t        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wraps    <= '0;
         limit_r  <= '0;
         reload_r <= 1'b0;
      end else begin
         t    <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  limit_r <= limit;
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
                  reload_r <= reload;
`else
                  reload_r <= 1'b0;
`endif
                  wraps <= '0;
                  busy  <= 1'b1;
                  if (limit == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN, HOLD: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (at_limit) begin
                  done <= 1'b1;
                  if (reload_r) begin
                     state <= RUN;
                     t     <= 1'b1;
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
                     wraps <= sat_inc(wraps);
`endif
                  end else begin
                     state <= DONE;
                  end
               end else if (pause) begin
                  state <= HOLD;
               end else begin
                  state <= RUN;
                  t     <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed testbench for count_sequencer; expectations follow the macro
// COUNT_SEQUENCER_AUTO_RELOAD_EN the same way the design does.
module tb_count_sequencer;
   import count_sequencer_pkg::*;

   logic             clk;
   logic             reset;
   logic             start;
   logic             stop;
   logic             pause;
   logic [CNT_W-1:0] limit;
   logic             reload;
   logic [CNT_W-1:0] q;
   logic             t;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] wraps;

   int errors = 0;
   int checks = 0;

   count_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .stop   (stop),
      .pause  (pause),
      .limit  (limit),
      .reload (reload),
      .q      (q),
      .t      (t),
      .busy   (busy),
      .done   (done),
      .wraps  (wraps)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b1; stop = 1'b0; pause = 1'b0; limit = 8'd5; reload = 1'b1;
      step();
      step();
      checks++; if (q !== 8'd0)     begin errors++; $display("FAIL reset_q got=%0d exp=0", q); end
      checks++; if (t !== 1'b0)     begin errors++; $display("FAIL reset_t got=%0b exp=0", t); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (wraps !== 8'd0) begin errors++; $display("FAIL reset_wraps got=%0d exp=0", wraps); end
      start = 1'b0; reload = 1'b0;
      reset = 1'b1;
      step();
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_oneshot();
      limit = 8'd5; reload = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      limit = 8'd2;
      checks++; if (q !== 8'd0 || busy !== 1'b1 || done !== 1'b0)
         begin errors++; $display("FAIL oneshot_start got q=%0d busy=%0b done=%0b exp q=0 busy=1 done=0", q, busy, done); end
      for (int k = 1; k <= 5; k++) begin
         step();
         checks++; if (q !== 8'(k) || t !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL oneshot_count k=%0d got q=%0d t=%0b done=%0b exp q=%0d t=1 done=0", k, q, t, done, k); end
      end
      step();
      checks++; if (q !== 8'd5 || t !== 1'b0 || done !== 1'b1 || busy !== 1'b1)
         begin errors++; $display("FAIL oneshot_done got q=%0d t=%0b done=%0b busy=%0b exp q=5 t=0 done=1 busy=1", q, t, done, busy); end
      step();
      checks++; if (q !== 8'd5 || done !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL oneshot_idle got q=%0d done=%0b busy=%0b exp q=5 done=0 busy=0", q, done, busy); end
   endtask

   task automatic test_start_in_done();
      limit = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      checks++; if (done !== 1'b1 || q !== 8'd1)
         begin errors++; $display("FAIL short_done got done=%0b q=%0d exp done=1 q=1", done, q); end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (busy !== 1'b0 || q !== 8'd1 || done !== 1'b0)
         begin errors++; $display("FAIL start_in_done got busy=%0b q=%0d done=%0b exp busy=0 q=1 done=0", busy, q, done); end
   endtask

   task automatic test_reload();
      logic [7:0] eq, ew;
      logic       ed, eb;
      limit = 8'd3; reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0; reload = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
         eq = 8'(k % 4); ed = (k % 4 == 0); eb = 1'b1; ew = 8'(k / 4);
`else
         eq = (k <= 3) ? 8'(k) : 8'd3; ed = (k == 4); eb = (k <= 4); ew = 8'd0;
`endif
         checks++; if (q !== eq || done !== ed || busy !== eb || wraps !== ew)
            begin errors++; $display("FAIL reload k=%0d got q=%0d done=%0b busy=%0b wraps=%0d exp q=%0d done=%0b busy=%0b wraps=%0d",
                                      k, q, done, busy, wraps, eq, ed, eb, ew); end
      end
`ifdef COUNT_SEQUENCER_AUTO_RELOAD_EN
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++; if (busy !== 1'b0 || q !== 8'd0 || done !== 1'b0)
         begin errors++; $display("FAIL reload_stop got busy=%0b q=%0d done=%0b exp busy=0 q=0 done=0", busy, q, done); end
      limit = 8'd1; reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 520; k++) step();
      checks++; if (wraps !== 8'd255)
         begin errors++; $display("FAIL wraps_sat got=%0d exp=255", wraps); end
      stop = 1'b1;
      step();
      stop = 1'b0; reload = 1'b0;
`endif
   endtask

   task automatic test_pause();
      limit = 8'd10; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) step();
      checks++; if (q !== 8'd4)
         begin errors++; $display("FAIL pause_pre got q=%0d exp=4", q); end
      pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (q !== 8'd4 || t !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL pause_hold c=%0d got q=%0d t=%0b busy=%0b exp q=4 t=0 busy=1", k, q, t, busy); end
      end
      pause = 1'b0;
      for (int k = 5; k <= 10; k++) begin
         step();
         checks++; if (q !== 8'(k) || t !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL pause_resume got q=%0d t=%0b done=%0b exp q=%0d t=1 done=0", q, t, done, k); end
      end
      step();
      checks++; if (done !== 1'b1 || q !== 8'd10)
         begin errors++; $display("FAIL pause_done got done=%0b q=%0d exp done=1 q=10", done, q); end
      step();
      checks++; if (busy !== 1'b0)
         begin errors++; $display("FAIL pause_idle got busy=%0b exp=0", busy); end
   endtask

   task automatic test_stop();
      limit = 8'd20; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 7; k++) step();
      checks++; if (q !== 8'd7)
         begin errors++; $display("FAIL stop_pre got q=%0d exp=7", q); end
      stop = 1'b1; start = 1'b1;
      step();
      checks++; if (q !== 8'd0 || busy !== 1'b0 || t !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL stop_abort got q=%0d busy=%0b t=%0b done=%0b exp q=0 busy=0 t=0 done=0", q, busy, t, done); end
      step();
      checks++; if (busy !== 1'b0 || q !== 8'd0)
         begin errors++; $display("FAIL stop_start_idle got busy=%0b q=%0d exp busy=0 q=0", busy, q); end
      stop = 1'b0; start = 1'b0;
      step();
      checks++; if (busy !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL stop_after got busy=%0b done=%0b exp busy=0 done=0", busy, done); end
   endtask

   task automatic test_reset_midrun();
      limit = 8'd20; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 9; k++) step();
      checks++; if (q !== 8'd9)
         begin errors++; $display("FAIL midrun_pre got q=%0d exp=9", q); end
      reset = 1'b0;
      step();
      reset = 1'b1;
      checks++; if (q !== 8'd0 || t !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wraps !== 8'd0)
         begin errors++; $display("FAIL midrun_reset got q=%0d t=%0b busy=%0b done=%0b wraps=%0d exp all 0", q, t, busy, done, wraps); end
      limit = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b1 || t !== 1'b0 || q !== 8'd0)
         begin errors++; $display("FAIL zero_done got done=%0b busy=%0b t=%0b q=%0d exp done=1 busy=1 t=0 q=0", done, busy, t, q); end
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0 || t !== 1'b0)
         begin errors++; $display("FAIL zero_idle got done=%0b busy=%0b t=%0b exp 0 0 0", done, busy, t); end
   endtask

   task automatic test_full_range();
      int bad;
      bad = 0;
      limit = 8'd255; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 255; k++) begin
         step();
         if (q !== 8'(k) || done !== 1'b0) bad++;
      end
      checks++; if (bad != 0)
         begin errors++; $display("FAIL full_range_count got bad_steps=%0d exp=0", bad); end
      step();
      checks++; if (done !== 1'b1 || q !== 8'd255)
         begin errors++; $display("FAIL full_range_done got done=%0b q=%0d exp done=1 q=255", done, q); end
      step();
      checks++; if (busy !== 1'b0 || q !== 8'd255)
         begin errors++; $display("FAIL full_range_idle got busy=%0b q=%0d exp busy=0 q=255", busy, q); end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_start_in_done();
      test_reload();
      test_pause();
      test_stop();
      test_reset_midrun();
      test_full_range();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL have port: start  input  1  request a count run; ignored while busy.
REQ-004 SHALL have port: stop  input  1  abort the current run.
REQ-005 SHALL have port: pause  input  1  level; freezes count while high.
REQ-006 SHALL have port: limit  input  8  terminal count, captured on accepted start.
REQ-007 SHALL have port: reload  input  1  auto-reload mode select, captured on accepted start.
REQ-008 SHALL have port: q  output  8  current count value.
REQ-009 SHALL have port: t  output  1  toggle-enable, high in every cycle the count advances.
REQ-010 SHALL have port: busy  output  1  high in RUN, HOLD and DONE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse per completed period.
REQ-012 SHALL have port: wraps  output  8  completed auto-reload periods, saturating at 255.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, HOLD, DONE; all outputs registered.
REQ-014 IDLE: start=1 and stop=0 SHALL capture limit/reload, set q=0, wraps=0, enter RUN.
REQ-015 start accepted with limit=0 SHALL enter DONE directly; no counting.
REQ-016 RUN, q!=limit_r, no stop or pause: q SHALL increment by 1 per clock; t=1.
REQ-017 RUN, q==limit_r, reload_r=0: q SHALL hold; state SHALL go to DONE.
REQ-018 RUN, q==limit_r, reload_r=1: q SHALL go to 0, wraps SHALL increment (saturating at 255), done SHALL pulse 1 cycle, state SHALL stay RUN.
REQ-019 Start edge E0 SHALL give q=k after E0+k; one-shot done SHALL be high for exactly the cycle after edge E0+limit+1.
REQ-020 RUN with pause=1 SHALL enter HOLD; q frozen; t=0.
REQ-021 HOLD with pause=0 SHALL return to RUN; counting resumes on the next edge.
REQ-022 stop=1 in RUN or HOLD SHALL enter IDLE with q=0 and t=0; no done pulse.
REQ-023 In-state priority SHALL be stop > terminal (q==limit_r) > pause.
REQ-024 DONE: done=1 for one cycle, then IDLE; q SHALL retain limit_r in IDLE.
REQ-025 start while busy SHALL be ignored, including in DONE.
REQ-026 start and stop together in IDLE: stop SHALL win; state stays IDLE.
REQ-027 limit and reload changes SHALL have no effect after capture.
REQ-028 q arithmetic SHALL be 8-bit unsigned; limit=255 SHALL count the full range without overflow.

Reset
REQ-029 reset=0 at a rising edge SHALL force IDLE, q=0, t=0, busy=0, done=0, wraps=0, limit_r=0, reload_r=0.
REQ-030 Reset asserted mid-run SHALL take effect on that edge, with no done pulse.
REQ-031 Reset SHALL override all other inputs.

Configuration
REQ-032 Macro COUNT_SEQUENCER_AUTO_RELOAD_EN defined: REQ-018 behaviour applies.
REQ-033 Macro undefined: reload SHALL be ignored (reload_r=0), wraps SHALL stay 0, and REQ-017 SHALL always apply.

Structure
REQ-034 A shared package SHALL hold the state enum type (IDLE/RUN/HOLD/DONE) and the width constant CNT_W=8.
REQ-035 The 8-bit count register with synchronous clear/enable SHALL be sub-module count8_core; the FSM, capture registers and wraps SHALL stay in count_sequencer.

Verification
REQ-036 limit=5, reload=0, start 1 cycle: q SHALL step 0..5; done SHALL pulse once 6 cycles after the start edge; busy SHALL drop the cycle after done.
REQ-037 limit=3, reload=1, run 12 cycles: q SHALL go 0,1,2,3,0,...; done SHALL pulse every 4 cycles; wraps SHALL read 3. With the macro undefined: one done, then IDLE.
REQ-038 limit=10, pause high at q=4 for 3 cycles: q SHALL hold 4 and t=0 for 3 cycles; done SHALL arrive 3 cycles later than without the pause.
REQ-039 stop at q=7 (limit=20): next q=0, IDLE, no done; a start in the same cycle as the stop SHALL be ignored.
REQ-040 reset=0 at q=9 mid-run: all outputs SHALL be 0 on that edge; limit=0 start SHALL give done the next cycle with t never high.
